// File: rtl/sram_like_arbiter_pkg.sv
// sram_like_arbiter_pkg: shared bus widths, owner tags and size encodings
package sram_like_arbiter_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   typedef enum logic {
      OWNER_INST = 1'b0,
      OWNER_DATA = 1'b1
   } owner_t;
   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } size_t;
endpackage

// File: rtl/sram_like_arbiter_if.sv
// sram_like_arbiter_if: one sram-like request/response channel
interface sram_like_arbiter_if;
   import sram_like_arbiter_pkg::*;
   logic              req;
   logic              wr;
   logic [1:0]        size;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              addr_ok;
   logic              data_ok;
   logic [DATA_W-1:0] rdata;
   modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
   modport slave  (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_arbiter_owner_fifo.sv
// sram_like_arbiter_owner_fifo: in-order owner tags of in-flight transactions
module sram_like_arbiter_owner_fifo
   import sram_like_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   i_push,
   input  owner_t i_din,
   input  logic   i_pop,
   output owner_t o_dout,
   output logic   o_full,
   output logic   o_empty
);
   localparam int PTR_W = $clog2(DEPTH);
   owner_t           r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;
   assign o_full  = r_count == CNT_W'(DEPTH);
   assign o_empty = r_count == '0;
   assign o_dout  = r_mem[r_rptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= OWNER_INST;
      end else begin
         if (w_push) r_mem[r_wptr] <= i_din;
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end
endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like port between inst and data requesters
module sram_like_arbiter
   import sram_like_arbiter_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   sram_like_arbiter_if.slave   inst,
   sram_like_arbiter_if.slave   data,
   sram_like_arbiter_if.master  mem,
   output logic                 ovf_err
);
   logic   r_lock_valid;
   owner_t r_lock_owner;
   owner_t w_grant;
   owner_t w_head;
   logic   w_full;
   logic   w_empty;
   logic   w_mem_req;
   logic   w_hs;
   logic   w_pop;
   logic   w_is_data;
   // a stalled request keeps its owner so the presented bus cannot change
   always_comb begin
      w_grant   = r_lock_valid ? r_lock_owner : (data.req ? OWNER_DATA : OWNER_INST);
      w_is_data = w_grant == OWNER_DATA;
      w_mem_req = !w_full && (r_lock_valid || inst.req || data.req);
      w_hs      = w_mem_req && mem.addr_ok;
      w_pop     = mem.data_ok && !w_empty;
   end
   // bus mux toward the shared port and same-cycle response routing
   always_comb begin
      mem.req       = w_mem_req;
      mem.wr        = w_is_data ? data.wr : inst.wr;
      mem.size      = w_is_data ? data.size : inst.size;
      mem.addr      = w_is_data ? data.addr : inst.addr;
      mem.wdata     = w_is_data ? data.wdata : inst.wdata;
      inst.addr_ok  = w_hs && !w_is_data;
      data.addr_ok  = w_hs && w_is_data;
      inst.data_ok  = w_pop && (w_head == OWNER_INST);
      data.data_ok  = w_pop && (w_head == OWNER_DATA);
      inst.rdata    = mem.rdata;
      data.rdata    = mem.rdata;
   end
   // lock on a refused address phase, release on its handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lock_valid <= 1'b0;
         r_lock_owner <= OWNER_INST;
      end else if (w_mem_req && !mem.addr_ok) begin
         r_lock_valid <= 1'b1;
         r_lock_owner <= w_grant;
      end else if (w_hs) begin
         r_lock_valid <= 1'b0;
      end
   end
   // sticky error for a response with nothing outstanding
   always_ff @(posedge clk) begin
      if (reset) ovf_err <= 1'b0;
      else if (mem.data_ok && w_empty) ovf_err <= 1'b1;
   end
   sram_like_arbiter_owner_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .CNT_W (CNT_W)
   ) u_owner_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_hs),
      .i_din   (w_grant),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );
endmodule
